mp_add_sched: RTL and testbench

MP_ADD_SCHED -- requirements
Module: mp_add_sched

---
 rtl/mp_add_sched.sv | 183 ++++++++++++++++++
 tb/tb_mp_add_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_sched.sv
// mp_add_sched: two-requester, round-robin scheduled multi-precision adder.
// Operands are W = 12*WORDS bits wide. One shared 12-bit tree adder processes
// one chunk per cycle, least significant chunk first.
// Optional feature: define MP_ADD_SCHED_SUBTRACT_EN to honour reqN_sub
// (a + ~b + 1). Without it the sub inputs are ignored and the block only adds.

// 12-bit parallel-prefix (Kogge-Stone style) adder with carry in/out.
module tree_12_adder (
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        cin,
  output logic [11:0] sum,
  output logic        cout
);

  logic [11:0] p0;
  logic [11:0] g_tree;

  assign p0 = a ^ b;

  // Prefix tree: g_tree[i] is the carry out of bit i, cin folded into bit 0.
  always_comb begin
    logic [11:0] g;
    logic [11:0] p;
    logic [11:0] g_nxt;
    logic [11:0] p_nxt;
    g    = a & b;
    p    = p0;
    g[0] = g[0] | (p0[0] & cin);
    for (int d = 1; d < 12; d = d * 2) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = d; i < 12; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i-d]);
        p_nxt[i] = p[i] & p[i-d];
      end
      g = g_nxt;
      p = p_nxt;
    end
    g_tree = g;
  end

  assign sum  = p0 ^ {g_tree[10:0], cin};
  assign cout = g_tree[11];

endmodule

module mp_add_sched #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [12*WORDS-1:0]   req0_a,
  input  logic [12*WORDS-1:0]   req0_b,
  input  logic                  req0_sub,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [12*WORDS-1:0]   req1_a,
  input  logic [12*WORDS-1:0]   req1_b,
  input  logic                  req1_sub,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [12*WORDS-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_id,
  output logic                  busy
);

  localparam int W  = 12 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;

  logic [W-1:0]    a_reg, b_reg, sum_reg;
  logic            sub_reg, id_reg, carry_reg, cout_reg;
  logic            last_grant_reg;   // 1: requester 1 was granted last
  logic [CW-1:0]   cnt_reg;

  logic            grant0, grant1, accept, sel_id, sel_sub, last_chunk;
  logic [W-1:0]    sel_a, sel_b;
  logic [11:0]     a_chunk, b_chunk, add_sum;
  logic            add_cout;

  // Round-robin: a lone requester wins; on a tie the one not granted last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

  // Readys are only ever high in IDLE, so either one high is a handshake.
  assign accept = req0_ready | req1_ready;
  assign sel_id = req1_ready;
  assign sel_a  = sel_id ? req1_a : req0_a;
  assign sel_b  = sel_id ? req1_b : req0_b;

`ifdef MP_ADD_SCHED_SUBTRACT_EN
  assign sel_sub = sel_id ? req1_sub : req0_sub;
`else
  logic unused_sub;
  assign sel_sub    = 1'b0;
  assign unused_sub = req0_sub ^ req1_sub;
`endif

  assign last_chunk = (cnt_reg == CW'(WORDS - 1));
  assign a_chunk    = a_reg[12*cnt_reg +: 12];
  assign b_chunk    = b_reg[12*cnt_reg +: 12] ^ {12{sub_reg}};

  tree_12_adder u_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and request handshake outputs; readys forced low during reset.
  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = grant0 && rst_n;
        req1_ready = grant1 && rst_n;
        if ((grant0 || grant1) && rst_n) state_next = RUN;
      end
      RUN: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, then one chunk per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg          <= '0;
      b_reg          <= '0;
      sum_reg        <= '0;
      sub_reg        <= 1'b0;
      id_reg         <= 1'b0;
      carry_reg      <= 1'b0;
      cout_reg       <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
    end else if (accept) begin
      a_reg          <= sel_a;
      b_reg          <= sel_b;
      sub_reg        <= sel_sub;
      id_reg         <= sel_id;
      last_grant_reg <= sel_id;
      carry_reg      <= sel_sub;  // chunk 0 carry in is the effective sub bit
      cnt_reg        <= '0;
    end else if (state_reg == RUN) begin
      sum_reg[12*cnt_reg +: 12] <= add_sum;
      cnt_reg                   <= cnt_reg + 1'b1;
      if (last_chunk) cout_reg  <= add_cout;   // top carry only reaches res_cout
      else            carry_reg <= add_cout;
    end
  end

  assign res_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign res_sum   = sum_reg;
  assign res_cout  = cout_reg;
  assign res_id    = id_reg;

endmodule

// File: tb/tb_mp_add_sched.sv
// Testbench for mp_add_sched (WORDS=4). Stimulus drives requests; a monitor
// process keeps a queue of expected results and compares whenever the DUT
// presents one. Honours MP_ADD_SCHED_SUBTRACT_EN like the design.
module tb_mp_add_sched;

  localparam int WORDS = 4;
  localparam int W     = 12 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_sub = 1'b0, req1_sub = 1'b0;
  logic          res_valid, res_cout, res_id, busy;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_sum;

  mp_add_sched #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  exp_t          q[$];
  logic          id_log[$];
  int            checks = 0, errors = 0;
  logic          inflight = 1'b0, last_rr = 1'b1, valid_seen = 1'b0;
  logic          e0, e1;
  int            acc_edge = 0, n_done = 0, rr_mode = 0;
  logic [W-1:0]  last_sum = '0;
  logic          last_cout = 1'b0, last_id = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: plain W-bit arithmetic; for subtract cout means no borrow.
  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic id);
    exp_t       e;
    logic [W:0] full;
    logic       s;
`ifdef MP_ADD_SCHED_SUBTRACT_EN
    s = sub;
`else
    s = 1'b0;
    if (sub) s = 1'b0;
`endif
    if (s) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      full   = {1'b0, a} + {1'b0, b};
      e.sum  = full[W-1:0];
      e.cout = full[W];
    end
    e.id = id;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        inflight   = 1'b0;
        last_rr    = 1'b1;
        valid_seen = 1'b0;
      end else begin
        e0 = !inflight && req0_valid && (!req1_valid || last_rr);
        e1 = !inflight && req1_valid && (!req0_valid || !last_rr);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("busy", busy, inflight);
        if (res_valid) begin
          if (q.size() == 0) begin
            chk("res_valid_unexpected", res_valid, 0);
          end else begin
            chk("res_sum", res_sum, q[0].sum);
            chk("res_cout", res_cout, q[0].cout);
            chk("res_id", res_id, q[0].id);
            if (!valid_seen) chk("latency", cyc - acc_edge, WORDS);
            valid_seen = 1'b1;
            if (res_ready) begin
              $display("[%0t] result id=%0d sum=%h cout=%0d", $time, res_id, res_sum, res_cout);
              last_sum  = res_sum;
              last_cout = res_cout;
              last_id   = res_id;
              id_log.push_back(res_id);
              void'(q.pop_front());
              n_done++;
              inflight   = 1'b0;
              valid_seen = 1'b0;
            end
          end
        end
        if (req0_valid && req0_ready) begin
          q.push_back(ref_op(req0_a, req0_b, req0_sub, 1'b0));
          inflight = 1'b1;
          acc_edge = cyc + 1;
          last_rr  = 1'b0;
        end else if (req1_valid && req1_ready) begin
          q.push_back(ref_op(req1_a, req1_b, req1_sub, 1'b1));
          inflight = 1'b1;
          acc_edge = cyc + 1;
          last_rr  = 1'b1;
        end
      end
    end
  end

  // Consumer: 0 always ready, 1 random, 2 stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Raise valid with operands, hold until accepted, then drop it.
  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1;
    end
    while (!got && n < 400) begin
      @(negedge clk);
      got = (id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
      n++;
    end
    if (!got) chk("accept_timeout", got, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n_done < target) chk("result_timeout", n_done, target);
  endtask

  int           base;
  logic [W-1:0] ones;

  initial begin
    ones = '1;
    // Reset with both requesters already valid: readys must stay low.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_res_cout", res_cout, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both requesters continuously valid: grants alternate starting with 0.
    fork
      begin
        for (int k = 0; k < 2; k++) issue(0, rnd_op(), rnd_op(), 1'b0);
      end
      begin
        for (int k = 0; k < 2; k++) issue(1, rnd_op(), rnd_op(), 1'b0);
      end
    join
    wait_done(4);
    for (int k = 0; k < 4; k++) begin
      if (k < id_log.size()) chk("rr_order", id_log[k], k % 2);
    end

    // Carry across one chunk boundary.
    base = n_done;
    issue(0, 48'h000000000FFF, 48'h000000000001, 1'b0);
    wait_done(base + 1);
    chk("dir_carry_sum", last_sum, 48'h000000001000);
    chk("dir_carry_cout", last_cout, 0);
    chk("dir_carry_id", last_id, 0);

    // Full ripple through every chunk into res_cout.
    base = n_done;
    issue(1, ones, 48'h000000000001, 1'b0);
    wait_done(base + 1);
    chk("dir_ripple_sum", last_sum, 48'h000000000000);
    chk("dir_ripple_cout", last_cout, 1);
    chk("dir_ripple_id", last_id, 1);

    // Consumer stalls in DONE while the other requester waits.
    base = n_done;
    rr_mode = 2;
    issue(0, rnd_op(), rnd_op(), 1'b0);
    for (int n = 0; n < 50 && !res_valid; n++) @(negedge clk);
    fork
      issue(1, rnd_op(), rnd_op(), 1'b0);
    join_none
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_req1_ready", req1_ready, 0);
    end
    rr_mode = 0;
    wait_done(base + 2);

    // Reset during chunk 2 discards the operation.
    base = n_done;
    issue(0, rnd_op(), rnd_op(), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_sum", res_sum, 0);
    chk("mid_rst_res_cout", res_cout, 0);
    chk("mid_rst_res_id", res_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req0_ready", req0_ready, 0);
    chk("mid_rst_req1_ready", req1_ready, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(0, 48'd3, 48'd4, 1'b0);
    wait_done(base + 1);
    chk("after_rst_sum", last_sum, 48'd7);
    chk("after_rst_id", last_id, 0);

    // Subtract request (honoured only with the subtract feature enabled).
    base = n_done;
    issue(1, 48'd5, 48'd7, 1'b1);
    wait_done(base + 1);
`ifdef MP_ADD_SCHED_SUBTRACT_EN
    chk("sub_sum", last_sum, 48'hFFFFFFFFFFFE);
`else
    chk("sub_sum", last_sum, 48'h00000000000C);
`endif
    chk("sub_cout", last_cout, 0);

    // Randomized traffic from both requesters with a random consumer.
    base = n_done;
    rr_mode = 1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue(0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue(1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
      end
    join
    rr_mode = 0;
    wait_done(base + 80);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    chk("random_done", n_done - base, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
